axis_pin_packetizer: RTL and testbench

- Successor to the fixed 8-to-32 pin capture source: samples a free-running parallel pin bus and packs samples into parametrised-width AXI4-Stream words.
- Buffers words in a parametrised FIFO with a registered first-word-fall-through output stage.
- Frames words into packets of programmable length (tlast), supports a flush that emits a partial word with correct tkeep, and counts words dropped on overflow instead of stalling capture.

---
 rtl/axis_pin_packetizer.sv | 246 ++++++++++++++++++++++++
 tb/tb_axis_pin_packetizer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pin_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_pin_packetizer
//  Description : Samples a free-running parallel pin bus, packs LANES samples
//                into one AXI4-Stream word, buffers the words in a FIFO with a
//                registered output stage, frames them into packets of
//                programmable length (tlast) and counts the words it drops
//                when the FIFO is full. Capture never stalls.
//
//  Ports
//    aclk, aresetn   : clock, asynchronous active-low reset
//    data_pins       : PIN_W-bit pin bus, sampled when capture_en=1
//    capture_en      : take one sample this cycle
//    flush           : close the partial word and end the current packet
//    pkt_len         : words per packet (0 behaves as 1)
//    overflow_clr    : synchronous clear of overflow_count
//    m_axis_*        : AXI4-Stream master (lane 0 in the LSBs of tdata)
//    overflow_count  : words dropped on a full FIFO, saturating at 0xFFFF
//    fifo_level      : FIFO occupancy, output register not included
//
//  Revision    : 1.0  initial release
// ============================================================================
module axis_pin_packetizer #(
    parameter int PIN_W           = 8,
    parameter int LANES           = 4,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int PKT_LEN_W       = 16
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [PIN_W-1:0]         data_pins,
    input  logic                     capture_en,
    input  logic                     flush,
    input  logic [PKT_LEN_W-1:0]     pkt_len,
    input  logic                     overflow_clr,
    output logic                     m_axis_tvalid,
    output logic [PIN_W*LANES-1:0]   m_axis_tdata,
    output logic [LANES-1:0]         m_axis_tkeep,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic [15:0]              overflow_count,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

    localparam int c_tdata_w = PIN_W * LANES;
    localparam int c_lane_w  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_fill_w  = $clog2(LANES + 1);
    localparam int c_depth   = 2 ** FIFO_DEPTH_LOG2;
    localparam int c_entry_w = 1 + LANES + c_tdata_w;

    localparam logic [c_lane_w-1:0]          c_last_lane = c_lane_w'(LANES - 1);
    localparam logic [FIFO_DEPTH_LOG2:0]     c_full_lvl  = (FIFO_DEPTH_LOG2 + 1)'(c_depth);
    localparam logic [PKT_LEN_W-1:0]         c_len_one   = PKT_LEN_W'(1);

    // ------------------------------------------------------------------
    // Word assembler state
    // ------------------------------------------------------------------
    logic [PIN_W-1:0]     r_lane [LANES];
    logic [c_lane_w-1:0]  r_lane_idx;

    // ------------------------------------------------------------------
    // Packet framing state
    // ------------------------------------------------------------------
    logic [PKT_LEN_W-1:0] r_word_idx;
    logic [PKT_LEN_W-1:0] r_len;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [c_entry_w-1:0]       r_mem [c_depth];
    logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_level;

    // ------------------------------------------------------------------
    // Output holding register and overflow counter
    // ------------------------------------------------------------------
    logic                 r_out_valid;
    logic [c_tdata_w-1:0] r_out_data;
    logic [LANES-1:0]     r_out_keep;
    logic                 r_out_last;
    logic [15:0]          r_ovf_cnt;

    // ------------------------------------------------------------------
    // Combinational word view: the stored lanes plus this cycle's sample
    // ------------------------------------------------------------------
    logic [c_fill_w-1:0]  w_fill;        // lanes filled once this cycle's sample lands
    logic [c_tdata_w-1:0] w_word_data;
    logic [LANES-1:0]     w_word_keep;
    logic                 w_word_full;
    logic                 w_wr_req;
    logic [PKT_LEN_W-1:0] w_len_in;
    logic [PKT_LEN_W-1:0] w_len_cur;
    logic                 w_last;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_wr_en;
    logic                 w_drop;
    logic                 w_rd_en;

    assign w_fill = c_fill_w'(r_lane_idx) + c_fill_w'(capture_en);

    // Each lane comes from the pins (if it is the one being sampled now),
    // from the lane registers (if filled earlier in this word) or is zero.
    // Masking here means stale lane registers from an earlier word never
    // leak into a flushed partial word, so the registers need no clearing.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_word_keep[gi] = (c_fill_w'(gi) < w_fill);
        assign w_word_data[gi*PIN_W +: PIN_W] =
            (capture_en && (r_lane_idx == c_lane_w'(gi))) ? data_pins :
            (c_fill_w'(gi) < c_fill_w'(r_lane_idx))      ? r_lane[gi] :
                                                            '0;
    end

    assign w_word_full = capture_en && (r_lane_idx == c_last_lane);
    assign w_wr_req    = w_word_full || (flush && (w_fill != '0));

    // The packet length is taken from the port only on the first word of a
    // packet; later words of the same packet use the latched copy so a
    // mid-packet change only affects the next packet.
    assign w_len_in  = (pkt_len == '0) ? c_len_one : pkt_len;
    assign w_len_cur = (r_word_idx == '0) ? w_len_in : r_len;
    assign w_last    = flush || (r_word_idx == (w_len_cur - c_len_one));

    // A full FIFO rejects the write even when a read happens in the same
    // cycle: the word is dropped whole rather than stalling the pins.
    assign w_fifo_full  = (r_level == c_full_lvl);
    assign w_fifo_empty = (r_level == '0);
    assign w_wr_en      = w_wr_req && !w_fifo_full;
    assign w_drop       = w_wr_req &&  w_fifo_full;
    assign w_rd_en      = !w_fifo_empty && (!r_out_valid || m_axis_tready);

    // ------------------------------------------------------------------
    // Assembler: lane index and lane storage
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lane_idx <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            if (capture_en) begin
                r_lane[r_lane_idx] <= data_pins;
            end
            if (flush || w_word_full) begin
                r_lane_idx <= '0;
            end else if (capture_en) begin
                r_lane_idx <= r_lane_idx + c_lane_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet framing: word index counts accepted words only, so dropped
    // words do not advance the packet position.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_word_idx <= '0;
            r_len      <= c_len_one;
        end else begin
            if (w_wr_en && (r_word_idx == '0)) begin
                r_len <= w_len_in;
            end
            if (flush) begin
                r_word_idx <= '0;
            end else if (w_wr_en) begin
                r_word_idx <= w_last ? '0 : (r_word_idx + c_len_one);
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (contents are only ever read after being written, so
    // the array itself carries no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {w_last, w_word_keep, w_word_data};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output holding register: reloads whenever it is empty or its word is
    // being consumed, which gives back-to-back valid words at full rate.
    // Payload is only touched on a reload, so it stays stable under stall.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_out_valid                           <= 1'b1;
                {r_out_last, r_out_keep, r_out_data}  <= r_mem[r_rd_ptr];
            end else if (m_axis_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Overflow counter: clear wins over a same-cycle increment
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ovf_cnt <= '0;
        end else if (overflow_clr) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

    assign m_axis_tvalid  = r_out_valid;
    assign m_axis_tdata   = r_out_data;
    assign m_axis_tkeep   = r_out_keep;
    assign m_axis_tlast   = r_out_last;
    assign overflow_count = r_ovf_cnt;
    assign fifo_level     = r_level;

endmodule
`default_nettype wire

// File: tb/tb_axis_pin_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_pin_packetizer
//  Description : Self-checking bench for axis_pin_packetizer (default
//                parameters). A queue-based reference model tracks samples,
//                buffered words and the output register; scenario tasks
//                compare the DUT against it and against fixed expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_pin_packetizer;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  data_pins;
    logic        capture_en;
    logic        flush;
    logic [15:0] pkt_len;
    logic        overflow_clr;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] overflow_count;
    logic [4:0]  fifo_level;

    int n_vec;
    int n_err;

    axis_pin_packetizer dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .data_pins      (data_pins),
        .capture_en     (capture_en),
        .flush          (flush),
        .pkt_len        (pkt_len),
        .overflow_clr   (overflow_clr),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .overflow_count (overflow_count),
        .fifo_level     (fifo_level)
    );

    always #5 aclk = ~aclk;

    // Observed payload and full observation (payload masked while invalid)
    wire [36:0] dut_pay = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
    wire [58:0] dut_obs = {m_axis_tvalid, (m_axis_tvalid ? dut_pay : 37'b0), fifo_level, overflow_count};
    wire [58:0] dut_raw = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, fifo_level, overflow_count};

    // ------------------------------------------------------------------
    // Reference model: samples of the open word, buffered words, output
    // register, packet position and drop counter.
    // ------------------------------------------------------------------
    logic [7:0]  m_lanes[$];
    logic [36:0] m_fifo[$];
    logic        m_out_valid;
    logic [36:0] m_out;
    int          m_word_idx;
    int          m_len;
    int          m_ovf;

    function automatic void model_reset();
        m_lanes.delete();
        m_fifo.delete();
        m_out_valid = 1'b0;
        m_out       = '0;
        m_word_idx  = 0;
        m_len       = 1;
        m_ovf       = 0;
    endfunction

    function automatic void model_step(logic cap, logic [7:0] pins, logic fl,
                                       logic [15:0] plen, logic clr, logic rdy);
        bit          full = (m_fifo.size() == 16);
        bit          pop  = (m_fifo.size() > 0) && (!m_out_valid || rdy);
        bit          hs   = m_out_valid && rdy;
        bit          acc  = 1'b0;
        logic [36:0] w    = '0;
        if (cap) m_lanes.push_back(pins);
        if (m_lanes.size() == 4 || (fl && m_lanes.size() > 0)) begin
            int          n   = m_lanes.size();
            int          eff;
            logic [31:0] d   = '0;
            logic        lst;
            for (int i = 0; i < n; i++) d |= 32'(m_lanes[i]) << (8 * i);
            eff = (m_word_idx == 0) ? ((plen == 0) ? 1 : int'(plen)) : m_len;
            lst = fl || (m_word_idx == eff - 1);
            w   = {lst, 4'((1 << n) - 1), d};
            m_lanes.delete();
            if (full) begin
                if (m_ovf < 65535) m_ovf++;
            end else begin
                acc = 1'b1;
                if (m_word_idx == 0) m_len = eff;
                m_word_idx = lst ? 0 : m_word_idx + 1;
            end
        end
        if (fl) m_word_idx = 0;
        if (clr) m_ovf = 0;
        if (pop) begin
            m_out       = m_fifo.pop_front();
            m_out_valid = 1'b1;
        end else if (hs) begin
            m_out_valid = 1'b0;
        end
        if (acc) m_fifo.push_back(w);
    endfunction

    function automatic logic [58:0] exp_obs();
        return {m_out_valid, (m_out_valid ? m_out : 37'b0), 5'(m_fifo.size()), 16'(m_ovf)};
    endfunction

    // One clock cycle of stimulus; the model advances with the same inputs.
    task automatic drive(input logic cap, input logic [7:0] pins, input logic fl,
                         input logic [15:0] plen, input logic clr, input logic rdy);
        capture_en    = cap;
        data_pins     = pins;
        flush         = fl;
        pkt_len       = plen;
        overflow_clr  = clr;
        m_axis_tready = rdy;
        @(posedge aclk);
        model_step(cap, pins, fl, plen, clr, rdy);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        #2;
        n_vec++;
        if (dut_raw !== '0) begin
            n_err++;
            $display("FAIL reset_during got=%h exp=0", dut_raw);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'h00, 1'b0, 16'd2, 1'b0, 1'b1);
            n_vec++;
            if (dut_raw !== '0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=0", k, dut_raw);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic();
        logic [36:0] got[$];
        int          first = -1;
        for (int k = 0; k < 14; k++) begin
            if (m_axis_tvalid) got.push_back(dut_pay);
            drive(k < 8, 8'(k + 1), 1'b0, 16'd2, 1'b0, 1'b1);
            if (m_axis_tvalid && first < 0) first = k;
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL basic_cycle k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
        n_vec++;
        if (first !== 4) begin
            n_err++;
            $display("FAIL basic_latency got=%0d exp=4", first);
        end
        n_vec++;
        if (got.size() !== 2) begin
            n_err++;
            $display("FAIL basic_count got=%0d exp=2", got.size());
        end else begin
            n_vec++;
            if (got[0] !== {1'b0, 4'hF, 32'h04030201}) begin
                n_err++;
                $display("FAIL basic_word0 got=%h exp=%h", got[0], {1'b0, 4'hF, 32'h04030201});
            end
            n_vec++;
            if (got[1] !== {1'b1, 4'hF, 32'h08070605}) begin
                n_err++;
                $display("FAIL basic_word1 got=%h exp=%h", got[1], {1'b1, 4'hF, 32'h08070605});
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow();
        logic [7:0]  b[400];
        logic [36:0] got[$];
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            b[i] = 8'($urandom);
            drive(1'b1, b[i], 1'b0, 16'd4, 1'b0, 1'b0);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL ovf_fill i=%0d got=%h exp=%h", i, dut_obs, exp_obs());
            end
        end
        n_vec++;
        if (fifo_level !== 5'd16 || overflow_count !== 16'd83) begin
            n_err++;
            $display("FAIL ovf_totals got level=%0d count=%0d exp level=16 count=83", fifo_level, overflow_count);
        end
        for (int k = 0; k < 25; k++) begin
            if (m_axis_tvalid) got.push_back(dut_pay);
            drive(1'b0, 8'h00, 1'b0, 16'd4, 1'b0, 1'b1);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL ovf_drain k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
        n_vec++;
        if (got.size() !== 17 || m_axis_tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_drain_count got=%0d valid=%b exp=17 valid=0", got.size(), m_axis_tvalid);
        end else begin
            for (int w = 0; w < 17; w++) begin
                logic [36:0] e;
                e = {(w % 4 == 3), 4'hF, b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
                n_vec++;
                if (got[w] !== e) begin
                    n_err++;
                    $display("FAIL ovf_word w=%0d got=%h exp=%h", w, got[w], e);
                end
            end
        end
        drive(1'b0, 8'h00, 1'b0, 16'd4, 1'b1, 1'b1);
        n_vec++;
        if (overflow_count !== 16'd0) begin
            n_err++;
            $display("FAIL ovf_clear got=%0d exp=0", overflow_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        // {capture_en, flush, byte}
        logic [9:0] seq[24] = '{10'h2AA, 10'h2BB, 10'h100, 10'h211, 10'h222, 10'h233,
                                10'h244, 10'h255, 10'h266, 10'h277, 10'h388, 10'h299,
                                10'h3AB, 10'h100, 10'h2C1, 10'h2C2, 10'h2C3, 10'h2C4,
                                10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        logic [36:0] exp_w[5] = '{{1'b1, 4'h3, 32'h0000BBAA}, {1'b0, 4'hF, 32'h44332211},
                                  {1'b1, 4'hF, 32'h88776655}, {1'b1, 4'h3, 32'h0000AB99},
                                  {1'b0, 4'hF, 32'hC4C3C2C1}};
        logic [36:0] got[$];
        for (int k = 0; k < 24; k++) begin
            if (m_axis_tvalid) got.push_back(dut_pay);
            drive(seq[k][9], seq[k][7:0], seq[k][8], 16'd2, 1'b0, 1'b1);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL flush_cycle k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
        n_vec++;
        if (got.size() !== 5) begin
            n_err++;
            $display("FAIL flush_count got=%0d exp=5", got.size());
        end else begin
            for (int w = 0; w < 5; w++) begin
                n_vec++;
                if (got[w] !== exp_w[w]) begin
                    n_err++;
                    $display("FAIL flush_word w=%0d got=%h exp=%h", w, got[w], exp_w[w]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_toggle();
        for (int k = 0; k < 300; k++) begin
            logic        rdy  = k[0];
            logic        pv   = m_out_valid;
            logic [36:0] ppay = m_out;
            drive(1'b1, 8'($urandom), 1'b0, 16'($urandom_range(1, 5)), 1'b0, rdy);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL toggle_cycle k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
            if (pv && !rdy) begin
                n_vec++;
                if (m_axis_tvalid !== 1'b1 || dut_pay !== ppay) begin
                    n_err++;
                    $display("FAIL toggle_stall k=%0d got=%b/%h exp=1/%h", k, m_axis_tvalid, dut_pay, ppay);
                end
            end
        end
        n_vec++;
        if (overflow_count !== 16'd0) begin
            n_err++;
            $display("FAIL toggle_ovf got=%0d exp=0", overflow_count);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        logic [7:0]  b[4];
        logic [36:0] got[$];
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 8'($urandom), 1'b0, 16'd3, 1'b0, 1'b0);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL areset_fill k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_vec++;
        if (dut_raw !== '0) begin
            n_err++;
            $display("FAIL areset_immediate got=%h exp=0", dut_raw);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) b[k] = 8'($urandom);
            if (m_axis_tvalid) got.push_back(dut_pay);
            drive(k < 4, (k < 4) ? b[k] : 8'h00, 1'b0, 16'd2, 1'b0, 1'b1);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL areset_after k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
        n_vec++;
        if (got.size() !== 1 || got[0] !== {1'b0, 4'hF, b[3], b[2], b[1], b[0]}) begin
            n_err++;
            $display("FAIL areset_word0 got n=%0d w=%h exp n=1 w=%h", got.size(),
                     (got.size() > 0) ? got[0] : 37'b0, {1'b0, 4'hF, b[3], b[2], b[1], b[0]});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_pkt_len();
        logic        exp_last[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [36:0] got[$];
        // Empty flush: writes nothing, only re-aligns the packet position
        drive(1'b0, 8'h00, 1'b1, 16'd0, 1'b0, 1'b1);
        n_vec++;
        if (dut_obs !== exp_obs()) begin
            n_err++;
            $display("FAIL pktlen_empty_flush got=%h exp=%h", dut_obs, exp_obs());
        end
        for (int k = 0; k < 50; k++) begin
            logic [15:0] pl = (k < 12) ? 16'd0 : (k < 16) ? 16'd3 : 16'd5;
            if (m_axis_tvalid) got.push_back(dut_pay);
            drive(k < 44, 8'($urandom), 1'b0, pl, 1'b0, 1'b1);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL pktlen_cycle k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
        n_vec++;
        if (got.size() !== 11) begin
            n_err++;
            $display("FAIL pktlen_count got=%0d exp=11", got.size());
        end else begin
            for (int w = 0; w < 11; w++) begin
                n_vec++;
                if (got[w][36] !== exp_last[w]) begin
                    n_err++;
                    $display("FAIL pktlen_tlast w=%0d got=%b exp=%b", w, got[w][36], exp_last[w]);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            logic rdy = ($urandom_range(0, 99) < ((k < 600) ? 15 : 60));
            drive($urandom_range(0, 99) < 75, 8'($urandom), $urandom_range(0, 99) < 4,
                  16'($urandom_range(0, 4)), $urandom_range(0, 99) < 2, rdy);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL random_cycle k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 8'h00, 1'b0, 16'd1, 1'b0, 1'b1);
            n_vec++;
            if (dut_obs !== exp_obs()) begin
                n_err++;
                $display("FAIL random_drain k=%0d got=%h exp=%h", k, dut_obs, exp_obs());
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        n_vec         = 0;
        n_err         = 0;
        aclk          = 1'b0;
        aresetn       = 1'b0;
        data_pins     = '0;
        capture_en    = 1'b0;
        flush         = 1'b0;
        pkt_len       = 16'd2;
        overflow_clr  = 1'b0;
        m_axis_tready = 1'b1;
        model_reset();

        test_reset();
        test_basic();
        test_overflow();
        test_flush();
        test_toggle();
        test_async_reset();
        test_pkt_len();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
